// File: rtl/signed_minmax_tracker_pkg.sv
// -----------------------------------------------------------------------------
// signed_minmax_tracker_pkg
// Shared types and constants for the signed min/max tracker:
//   - state_e     : tracker FSM states (IDLE / ACCUM / REPORT)
//   - cmp_res_e   : encoded result of a signed comparison (lt / eq / gt)
//   - DEFAULT_WIDTH : default sample width
//   - cmp_encode  : folds the three one-hot compare flags into cmp_res_e
// -----------------------------------------------------------------------------
package signed_minmax_tracker_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_e;

  // Exactly one flag is expected to be set; anything else collapses to EQ so
  // that a corrupted compare never triggers a min/max update.
  function automatic cmp_res_e cmp_encode(input logic lt, input logic eq, input logic gt);
    cmp_res_e res;
    case ({lt, eq, gt})
      3'b100:  res = CMP_LT;
      3'b010:  res = CMP_EQ;
      3'b001:  res = CMP_GT;
      default: res = CMP_EQ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/signed_minmax_tracker_cmp_unit.sv
// -----------------------------------------------------------------------------
// signed_cmp_unit
// Purely combinational two's-complement comparator: sign first, then magnitude.
// Ports:
//   a, b    : WIDTH-bit signed operands
//   a_lt_b  : a <  b (signed)
//   a_eq_b  : a == b
//   a_gt_b  : a >  b (signed)
// -----------------------------------------------------------------------------
module signed_cmp_unit
  import signed_minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             a_gt_b
);

  logic a_neg_s;
  logic b_neg_s;
  logic low_lt_s;

  assign a_neg_s = a[WIDTH-1];
  assign b_neg_s = b[WIDTH-1];
  // With equal signs, the lower bits order two's-complement values correctly
  // for both positive and negative operands.
  assign low_lt_s = (a[WIDTH-2:0] < b[WIDTH-2:0]);

  // Sign decides when signs differ; otherwise the remaining bits decide.
  always_comb begin
    a_eq_b = (a == b);
    if (a_neg_s != b_neg_s) begin
      a_lt_b = a_neg_s;
    end else begin
      a_lt_b = low_lt_s;
    end
    a_gt_b = ~a_lt_b & ~a_eq_b;
  end

endmodule

// File: rtl/signed_minmax_tracker.sv
// -----------------------------------------------------------------------------
// signed_minmax_tracker
// Consumes a stream of signed samples and reports the signed min/max of each
// window of WINDOW samples (or a shorter window closed by flush) over a
// valid/ready handshake.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   clear            : abort current window and any pending report
//   flush            : close the current window early
//   in_valid/in_ready/in_data : sample input handshake
//   out_valid/out_ready       : report handshake
//   out_min/out_max  : signed extremes of the reported window
//   out_count        : number of samples in the reported window
//   out_all_eq       : out_min == out_max
// -----------------------------------------------------------------------------
module signed_minmax_tracker
  import signed_minmax_tracker_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int WINDOW = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_count,
  output logic             out_all_eq
);

  state_e             state_q,      state_d;
  logic [CNT_W-1:0]   count_q,      count_d;
  logic [WIDTH-1:0]   min_q,        min_d;
  logic [WIDTH-1:0]   max_q,        max_d;
  logic [WIDTH-1:0]   out_min_q,    out_min_d;
  logic [WIDTH-1:0]   out_max_q,    out_max_d;
  logic [CNT_W-1:0]   out_count_q,  out_count_d;
  logic               out_all_eq_q, out_all_eq_d;
  logic               out_valid_q,  out_valid_d;

  logic               accept_s;
  logic               min_lt_s, min_eq_s, min_gt_s;
  logic               max_lt_s, max_eq_s, max_gt_s;
  cmp_res_e           vs_min_s;
  cmp_res_e           vs_max_s;
  logic [CNT_W-1:0]   count_inc_s;

  // Sample vs running minimum.
  signed_cmp_unit #(.WIDTH(WIDTH)) u_cmp_min (
    .a      (in_data),
    .b      (min_q),
    .a_lt_b (min_lt_s),
    .a_eq_b (min_eq_s),
    .a_gt_b (min_gt_s)
  );

  // Sample vs running maximum.
  signed_cmp_unit #(.WIDTH(WIDTH)) u_cmp_max (
    .a      (in_data),
    .b      (max_q),
    .a_lt_b (max_lt_s),
    .a_eq_b (max_eq_s),
    .a_gt_b (max_gt_s)
  );

  assign vs_min_s    = cmp_encode(min_lt_s, min_eq_s, min_gt_s);
  assign vs_max_s    = cmp_encode(max_lt_s, max_eq_s, max_gt_s);
  assign count_inc_s = count_q + CNT_W'(1);

  assign in_ready  = ~reset & ~clear & (state_q != ST_REPORT);
  assign accept_s  = in_valid & in_ready;

  assign out_valid  = out_valid_q;
  assign out_min    = out_min_q;
  assign out_max    = out_max_q;
  assign out_count  = out_count_q;
  assign out_all_eq = out_all_eq_q;

  // Next-state, accumulator and report-capture logic.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    min_d        = min_q;
    max_d        = max_q;
    out_min_d    = out_min_q;
    out_max_d    = out_max_q;
    out_count_d  = out_count_q;
    out_all_eq_d = out_all_eq_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          min_d   = in_data;
          max_d   = in_data;
          count_d = CNT_W'(1);
          if ((WINDOW == 32'sd1) || flush) begin
            state_d = ST_REPORT;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          // flush without a sample has nothing to report.
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          count_d = count_inc_s;
          if (vs_min_s == CMP_LT) begin
            min_d = in_data;
          end else begin
            min_d = min_q;
          end
          if (vs_max_s == CMP_GT) begin
            max_d = in_data;
          end else begin
            max_d = max_q;
          end
          if ((count_inc_s == CNT_W'(WINDOW)) || flush) begin
            state_d = ST_REPORT;
          end else begin
            state_d = ST_ACCUM;
          end
        end else if (flush) begin
          state_d = ST_REPORT;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_REPORT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          count_d = CNT_W'(0);
        end else begin
          state_d = ST_REPORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = CNT_W'(0);
      end
    endcase

    // Latch the report only on entry to REPORT so it stays stable while stalled
    // and persists after the handshake.
    if ((state_d == ST_REPORT) && (state_q != ST_REPORT)) begin
      out_min_d    = min_d;
      out_max_d    = max_d;
      out_count_d  = count_d;
      out_all_eq_d = (min_d == max_d);
    end else begin
      out_min_d    = out_min_q;
    end

    // clear drops the window and any pending report but keeps old report values.
    if (clear) begin
      state_d      = ST_IDLE;
      count_d      = CNT_W'(0);
      out_min_d    = out_min_q;
      out_max_d    = out_max_q;
      out_count_d  = out_count_q;
      out_all_eq_d = out_all_eq_q;
    end else begin
      count_d      = count_d;
    end

    out_valid_d = (state_d == ST_REPORT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      min_q        <= '0;
      max_q        <= '0;
      out_min_q    <= '0;
      out_max_q    <= '0;
      out_count_q  <= '0;
      out_all_eq_q <= 1'b1;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      min_q        <= min_d;
      max_q        <= max_d;
      out_min_q    <= out_min_d;
      out_max_q    <= out_max_d;
      out_count_q  <= out_count_d;
      out_all_eq_q <= out_all_eq_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_signed_minmax_tracker
// Directed bench for signed_minmax_tracker with WINDOW=4. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_signed_minmax_tracker;

  localparam int WIDTH  = 4;
  localparam int WINDOW = 4;
  localparam int CNT_W  = 8;

  logic             clk;
  logic             reset;
  logic             clear;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_count;
  logic             out_all_eq;

  int n_vec;
  int n_miss;

  signed_minmax_tracker #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_min    (out_min),
    .out_max    (out_max),
    .out_count  (out_count),
    .out_all_eq (out_all_eq)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample for one cycle (optionally with flush).
  task automatic send(input logic [WIDTH-1:0] d, input logic f);
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic check_report(input string tag, input logic [WIDTH-1:0] mn,
                              input logic [WIDTH-1:0] mx, input logic [CNT_W-1:0] cnt,
                              input logic eq);
    check_val({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_val({tag, ".min"},   32'(out_min),   32'(mn));
    check_val({tag, ".max"},   32'(out_max),   32'(mx));
    check_val({tag, ".count"}, 32'(out_count), 32'(cnt));
    check_val({tag, ".all_eq"},32'(out_all_eq),32'(eq));
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;

    // Reset state.
    step();
    step();
    check_val("rst.valid",    32'(out_valid),  32'd0);
    check_val("rst.min",      32'(out_min),    32'd0);
    check_val("rst.max",      32'(out_max),    32'd0);
    check_val("rst.count",    32'(out_count),  32'd0);
    check_val("rst.all_eq",   32'(out_all_eq), 32'd1);
    check_val("rst.in_ready", 32'(in_ready),   32'd0);
    reset = 1'b0;
    #1;
    check_val("rst.in_ready_after", 32'(in_ready), 32'd1);

    // flush in IDLE without a sample is ignored.
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("idle_flush.valid", 32'(out_valid), 32'd0);

    // Window 3,-2,7,0 with out_ready held high.
    out_ready = 1'b1;
    send(4'd3, 1'b0);
    send(4'b1110, 1'b0);
    send(4'd7, 1'b0);
    check_val("w1.valid_early", 32'(out_valid), 32'd0);
    send(4'd0, 1'b0);
    check_report("w1", 4'b1110, 4'b0111, 8'd4, 1'b0);
    check_val("w1.in_ready", 32'(in_ready), 32'd0);
    step();
    check_val("w1.hs_valid",    32'(out_valid), 32'd0);
    check_val("w1.hs_in_ready", 32'(in_ready),  32'd1);
    check_val("w1.persist_min", 32'(out_min),   32'(4'b1110));
    out_ready = 1'b0;

    // Sign-boundary extremes -8,7,-8,7.
    send(4'b1000, 1'b0);
    send(4'b0111, 1'b0);
    send(4'b1000, 1'b0);
    send(4'b0111, 1'b0);
    check_report("w2", 4'b1000, 4'b0111, 8'd4, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val("w2.hs_valid", 32'(out_valid), 32'd0);

    // Stall: window 6,1,-3,2 held for 5 cycles with extra samples offered.
    send(4'd6, 1'b0);
    send(4'd1, 1'b0);
    send(4'b1101, 1'b0);
    send(4'd2, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      check_report("stall", 4'b1101, 4'b0110, 8'd4, 1'b0);
      check_val("stall.in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val("stall.hs_valid",    32'(out_valid), 32'd0);
    check_val("stall.hs_in_ready", 32'(in_ready),  32'd1);

    // 5,5 then flush with a third 5: short window of three equal samples.
    send(4'd5, 1'b0);
    send(4'd5, 1'b0);
    send(4'd5, 1'b1);
    check_report("flush", 4'd5, 4'd5, 8'd3, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 1,2 then clear (with a -8 offered, which must be dropped): no report.
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'b1000;
    #1;
    check_val("clr.in_ready", 32'(in_ready), 32'd0);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    step();
    check_val("clr.valid",     32'(out_valid), 32'd0);
    check_val("clr.keep_count",32'(out_count), 32'd3);
    send(4'd4, 1'b0);
    send(4'b1111, 1'b0);
    send(4'b1111, 1'b0);
    send(4'b1111, 1'b0);
    check_report("post_clr", 4'b1111, 4'd4, 8'd4, 1'b0);

    // Reset while a report is pending.
    reset = 1'b1;
    step();
    check_val("rst2.valid",    32'(out_valid),  32'd0);
    check_val("rst2.min",      32'(out_min),    32'd0);
    check_val("rst2.max",      32'(out_max),    32'd0);
    check_val("rst2.count",    32'(out_count),  32'd0);
    check_val("rst2.all_eq",   32'(out_all_eq), 32'd1);
    check_val("rst2.in_ready", 32'(in_ready),   32'd0);
    reset = 1'b0;
    #1;
    check_val("rst2.in_ready_after", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
